// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and
// shared-memory wait freezes guarded by a watchdog that latches a sticky error.
module hazard_control_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             id_rs1_addr_in,
    input  logic [4:0]             id_rs2_addr_in,
    input  logic                   id_uses_rs1_in,
    input  logic                   id_uses_rs2_in,
    input  logic                   ex_mem_read_in,
    input  logic [4:0]             ex_rd_addr_in,
    input  logic                   ex_branch_taken_in,
    input  logic                   mem_req_in,
    input  logic                   mem_ready_in,
    output logic                   pc_write_en_out,
    output logic                   if_id_write_en_out,
    output logic                   if_id_flush_out,
    output logic                   id_ex_bubble_out,
    output logic                   id_ex_hold_out,
    output logic                   ex_mem_hold_out,
    output logic                   mem_timeout_err_out,
    output logic [STALL_CNT_W-1:0] stall_cycles_out
);
    localparam int CW = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;
    logic          err_q;
    logic          load_use, mem_wait, freeze;

    assign load_use = ex_mem_read_in && (ex_rd_addr_in != 5'd0) &&
                      ((id_uses_rs1_in && (id_rs1_addr_in == ex_rd_addr_in)) ||
                       (id_uses_rs2_in && (id_rs2_addr_in == ex_rd_addr_in)));
    assign mem_wait = mem_req_in && !mem_ready_in;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        freeze       = 1'b0;
        case (state)
            S_RUN: begin
                if (mem_wait) begin
                    freeze       = 1'b1;
                    state_nxt    = S_WAIT;
                    wait_cnt_nxt = CW'(1);
                end
            end
            S_WAIT: begin
                // Release evaluates like RUN in the same cycle, so no dead cycle
                if (!mem_wait) begin
                    state_nxt    = S_RUN;
                    wait_cnt_nxt = '0;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt == CW'(MEM_TIMEOUT - 1))
                        state_nxt = S_ERR;
                    else
                        wait_cnt_nxt = wait_cnt + CW'(1);
                end
            end
            S_ERR:   freeze = 1'b1;
            default: begin
                freeze    = 1'b1;
                state_nxt = S_RUN;
            end
        endcase
    end

    always_comb begin
        pc_write_en_out    = 1'b1;
        if_id_write_en_out = 1'b1;
        if_id_flush_out    = 1'b0;
        id_ex_bubble_out   = 1'b0;
        id_ex_hold_out     = 1'b0;
        ex_mem_hold_out    = 1'b0;
        if (!rst_n) begin
            pc_write_en_out    = 1'b0;
            if_id_write_en_out = 1'b0;
            id_ex_bubble_out   = 1'b1;
        end else if (freeze) begin
            pc_write_en_out    = 1'b0;
            if_id_write_en_out = 1'b0;
            id_ex_hold_out     = 1'b1;
            ex_mem_hold_out    = 1'b1;
        end else if (ex_branch_taken_in) begin
            // Branch wins over load-use: the ID instruction is wrong-path anyway
            if_id_flush_out  = 1'b1;
            id_ex_bubble_out = 1'b1;
        end else if (load_use) begin
            pc_write_en_out    = 1'b0;
            if_id_write_en_out = 1'b0;
            id_ex_bubble_out   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_RUN;
            wait_cnt         <= '0;
            err_q            <= 1'b0;
            stall_cycles_out <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            err_q    <= err_q || (state_nxt == S_ERR);
            if (!pc_write_en_out && (stall_cycles_out != '1))
                stall_cycles_out <= stall_cycles_out + STALL_CNT_W'(1);
        end
    end

    assign mem_timeout_err_out = err_q;
endmodule
